// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped I/O block for the 0x8000_0000 space.
// Provides RX/TX byte FIFOs between the core and the UART, sticky error
// flags, and cycle / retired-instruction counters behind a one-cycle
// latency load/store port.
//
// UART handshakes use valid/ready: a byte moves on a rising edge where
// both valid and ready are high. RX ready is tied high; a byte arriving
// with the RX FIFO full (and no pop that cycle) is dropped and flagged.
module io_mmio_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic        io_re,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    // Word offsets (io_addr[7:2]).
    localparam logic [5:0] A_STATUS   = 6'h00;
    localparam logic [5:0] A_RX_DATA  = 6'h01;
    localparam logic [5:0] A_TX_DATA  = 6'h02;
    localparam logic [5:0] A_CYCLE    = 6'h04;
    localparam logic [5:0] A_INST     = 6'h05;
    localparam logic [5:0] A_CNT_CLR  = 6'h06;
    localparam logic [5:0] A_FLAG_CLR = 6'h07;

    // Address bits [1:0] and the upper store-data bytes carry no meaning here.
    logic w_unused;
    assign w_unused = ^{io_addr[1:0], io_din[31:8]};

    logic [5:0] w_word;
    logic       w_wr;
    assign w_word = io_addr[7:2];
    assign w_wr   = |io_we;

    // ---------------- RX FIFO state ----------------
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr;
    logic [RX_AW-1:0] r_rx_rptr;
    logic [RX_AW:0]   r_rx_count;

    // ---------------- TX FIFO state ----------------
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wptr;
    logic [TX_AW-1:0] r_tx_rptr;
    logic [TX_AW:0]   r_tx_count;

    // ---------------- flags, counters, read data ----------------
    logic             r_rx_ovf;
    logic             r_tx_drop;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_inst;
    logic [31:0]      r_dout;

    logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    assign w_rx_full  = (r_rx_count == (RX_AW+1)'(RX_DEPTH));
    assign w_rx_empty = (r_rx_count == '0);
    assign w_tx_full  = (r_tx_count == (TX_AW+1)'(TX_DEPTH));
    assign w_tx_empty = (r_tx_count == '0);

    // Decoded accesses.
    logic w_rd_rx, w_wr_tx, w_cnt_clr, w_flag_clr;
    assign w_rd_rx    = io_re && (w_word == A_RX_DATA);
    assign w_wr_tx    = w_wr && (w_word == A_TX_DATA);
    assign w_cnt_clr  = w_wr && (w_word == A_CNT_CLR);
    assign w_flag_clr = w_wr && (w_word == A_FLAG_CLR);

    // FIFO events. A pop in the same cycle frees the slot a full FIFO needs.
    logic w_rx_pop, w_rx_push, w_rx_ovf_set;
    logic w_tx_pop, w_tx_push, w_tx_drop_set;
    assign w_rx_pop      = w_rd_rx && !w_rx_empty;
    assign w_rx_push     = uart_rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf_set  = uart_rx_valid && w_rx_full && !w_rx_pop;
    assign w_tx_pop      = uart_tx_valid && uart_tx_ready;
    assign w_tx_push     = w_wr_tx && (!w_tx_full || w_tx_pop);
    assign w_tx_drop_set = w_wr_tx && w_tx_full && !w_tx_pop;

    logic [7:0] w_rx_head;
    assign w_rx_head = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];

    assign uart_rx_ready = 1'b1;
    assign uart_tx_valid = !w_tx_empty;
    assign uart_tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
    assign io_dout       = r_dout;

    logic [31:0] w_status;
    assign w_status = {8'h00, 8'(r_tx_count), 8'(r_rx_count), 4'h0,
                       r_tx_drop, r_rx_ovf, !w_rx_empty, !w_tx_full};

    // Read mux: value captured into io_dout at the edge io_re is sampled.
    logic [31:0] w_rdata;
    always_comb begin
        w_rdata = '0;
        case (w_word)
            A_STATUS:  w_rdata = w_status;
            A_RX_DATA: w_rdata = {24'h0, w_rx_head};
            A_CYCLE:   w_rdata = 32'(r_cyc);
            A_INST:    w_rdata = 32'(r_inst);
            default:   w_rdata = '0;
        endcase
    end

    // FIFO storage writes; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= io_din[7:0];
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + (RX_AW+1)'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - (RX_AW+1)'(1);
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + (TX_AW+1)'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - (TX_AW+1)'(1);
        end
    end

    // Sticky error flags: a set in the same cycle as FLAG_CLR wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovf  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            if (w_rx_ovf_set)    r_rx_ovf <= 1'b1;
            else if (w_flag_clr) r_rx_ovf <= 1'b0;
            if (w_tx_drop_set)   r_tx_drop <= 1'b1;
            else if (w_flag_clr) r_tx_drop <= 1'b0;
        end
    end

    // Free-running cycle and retired-instruction counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else begin
            r_cyc <= r_cyc + CNT_W'(1);
            if (inst_retire) r_inst <= r_inst + CNT_W'(1);
        end
    end

    // Registered read data; holds while io_re is low.
    always_ff @(posedge clk) begin
        if (rst)        r_dout <= '0;
        else if (io_re) r_dout <= w_rdata;
    end

endmodule
